divide_recombine: RTL and testbench

Sequential inverse of the team's combinational divider. It consumes the divider's packed `{quotient, remainder}` byte together with the divisor and rebuilds the dividend as `quotient*divisor + remainder` using a shift-add loop. It also flags inconsistent input triples. It sits downstream of the divider as a self-check and round-trip stage, behind a start/done handshake.

---
 rtl/divide_pkg.sv | 44 ++++
 rtl/shift_add_unit.sv | 49 ++++
 rtl/divide_recombine.sv | 136 +++++++++++++
 tb/tb_divide_recombine.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/divide_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : divide_pkg
//  Brief    : Shared definitions for the divider family: default operand
//             width, recombiner state encoding and {quotient, remainder}
//             pack/unpack helpers.
//  Revision : 1.0
// ============================================================================
package divide_pkg;

  // Default operand width for quotient, remainder and divisor
  localparam int unsigned c_default_width = 4;

  // Recombiner control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Packs quotient (upper half) and remainder (lower half) like the divider output
  function automatic logic [2*c_default_width-1:0] pack_qr(
    input logic [c_default_width-1:0] q,
    input logic [c_default_width-1:0] r
  );
    return {q, r};
  endfunction

  // Extracts the quotient field from a packed divider result
  function automatic logic [c_default_width-1:0] unpack_q(
    input logic [2*c_default_width-1:0] p
  );
    return p[2*c_default_width-1:c_default_width];
  endfunction

  // Extracts the remainder field from a packed divider result
  function automatic logic [c_default_width-1:0] unpack_r(
    input logic [2*c_default_width-1:0] p
  );
    return p[c_default_width-1:0];
  endfunction

endpackage : divide_pkg
`default_nettype wire

// File: rtl/shift_add_unit.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_unit
//  Brief    : Shift-add multiply-accumulate datapath. On load it seeds the
//             accumulator with the remainder; each step conditionally adds
//             the shifted divisor, building quotient*divisor + remainder.
//  Revision : 1.0
// ============================================================================
module shift_add_unit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   remainder,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  // Load operands on accept, then one conditional add and shift per step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (load) begin
      r_acc    <= {{WIDTH{1'b0}}, remainder};
      r_mcand  <= {{WIDTH{1'b0}}, divisor};
      r_mplier <= quotient;
    end else if (step) begin
      // Full 2*WIDTH-bit sum: the largest result still fits without wrap
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign acc = r_acc;

endmodule : shift_add_unit
`default_nettype wire

// File: rtl/divide_recombine.sv
`default_nettype none
// ============================================================================
//  Module   : divide_recombine
//  Brief    : Sequential inverse of the combinational divider. Rebuilds
//             dividend = quotient*divisor + remainder over WIDTH cycles
//             behind a start/done handshake.
//             Optional macro DIVIDE_RECOMBINE_CHECK_EN adds an input
//             consistency flag on `error`; otherwise `error` is tied low.
//  Revision : 1.0
// ============================================================================
module divide_recombine
  import divide_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] packed_in,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] dividend,
  output logic               error
);

  localparam int unsigned        c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  state_e             r_state;
  logic [c_cnt_w-1:0] r_count;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_dividend;

  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic               w_load;
  logic               w_step;
  logic [2*WIDTH-1:0] w_acc;

  assign w_quot = packed_in[2*WIDTH-1:WIDTH];
  assign w_rem  = packed_in[WIDTH-1:0];

  // Operands are captured only on the accepting edge; start is ignored elsewhere
  assign w_load = (r_state == IDLE) && start;
  assign w_step = (r_state == RUN);

  shift_add_unit #(
    .WIDTH (WIDTH)
  ) u_shift_add (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .step      (w_step),
    .quotient  (w_quot),
    .remainder (w_rem),
    .divisor   (divisor),
    .acc       (w_acc)
  );

  // Control FSM: iteration counter, busy/done handshake and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dividend <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // busy stays up through the done cycle and drops at the following
          // edge unless a new request is accepted right there
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_count <= '0;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_count <= r_count + 1'b1;
          if (r_count == c_last) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_dividend <= w_acc;
          r_done     <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign dividend = r_dividend;

`ifdef DIVIDE_RECOMBINE_CHECK_EN
  logic w_err_cond;
  logic r_err_pending;
  logic r_error;

  // Remainder must be below a nonzero divisor; a zero divisor implies an all-zero result
  assign w_err_cond = ((divisor != '0) && (w_rem >= divisor)) ||
                      ((divisor == '0) && (packed_in != '0));

  // Capture the consistency verdict on accept and publish it alongside dividend
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_pending <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      if (w_load) begin
        r_err_pending <= w_err_cond;
      end
      if (r_state == DONE) begin
        r_error <= r_err_pending;
      end
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule : divide_recombine
`default_nettype wire

// File: tb/tb_divide_recombine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divide_recombine
//  Brief    : Self-checking bench for divide_recombine (WIDTH=4) against an
//             arithmetic reference of quotient*divisor + remainder.
//  Revision : 1.0
// ============================================================================
module tb_divide_recombine;
  import divide_pkg::*;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2*W-1:0] packed_in;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*W-1:0] dividend;
  logic           error;

  int n_vec;
  int n_bad;

  divide_recombine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .packed_in (packed_in),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .dividend  (dividend),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic and the consistency rule
  function automatic int ref_dividend(input int q, input int r, input int b);
    return q * b + r;
  endfunction

  function automatic bit ref_error(input int q, input int r, input int b);
`ifdef DIVIDE_RECOMBINE_CHECK_EN
    return ((b != 0) && (r >= b)) || ((b == 0) && ((q != 0) || (r != 0)));
`else
    return 1'b0;
`endif
  endfunction

  // Drive a request from a point away from the edge; returns #1 after the accept edge
  task automatic issue(input int q, input int r, input int b);
    start     = 1'b1;
    packed_in = pack_qr(W'(q), W'(r));
    divisor   = W'(b);
    @(posedge clk); #1;
    start     = 1'b0;
    packed_in = 8'($urandom);
    divisor   = 4'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait for done with a bound; 'already' is edges elapsed since accept
  task automatic await_result(input int q, input int r, input int b, input int already);
    int  i;
    bit  seen;
    i    = already;
    seen = 1'b0;
    while (i < 20 && !seen) begin
      @(posedge clk); #1;
      i++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(i), 32'(W + 1));
    check("dividend", 32'(dividend), 32'(ref_dividend(q, r, b)));
    check("error", 32'(error), 32'(ref_error(q, r, b)));
    check("busy_in_done", 32'(busy), 32'd1);
  endtask

  task automatic idle_after(input int q, input int r, input int b);
    @(posedge clk); #1;
    check("done_pulse_end", 32'(done), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
    check("dividend_hold", 32'(dividend), 32'(ref_dividend(q, r, b)));
    check("error_hold", 32'(error), 32'(ref_error(q, r, b)));
  endtask

  task automatic full_op(input int q, input int r, input int b);
    @(negedge clk);
    issue(q, r, b);
    await_result(q, r, b, 0);
    idle_after(q, r, b);
  endtask

  task automatic quiet(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check("no_spurious_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int q, r, b;
    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    packed_in = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dividend", 32'(dividend), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    full_op(3, 2, 5);
    full_op(15, 14, 15);
    full_op(0, 0, 0);
    full_op(1, 2, 0);
    full_op(1, 6, 4);

    // Start ignored while busy; chained start during the done cycle is accepted
    @(negedge clk);
    issue(2, 1, 3);
    @(posedge clk); #1;
    start = 1'b1; packed_in = pack_qr(4'd9, 4'd9); divisor = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    await_result(2, 1, 3, 2);
    issue(5, 3, 7);
    await_result(5, 3, 7, 0);
    idle_after(5, 3, 7);
    quiet(8);

    // Randomized round trips
    for (int n = 0; n < 40; n++) begin
      q = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      if ((n % 2) == 0 && b != 0) r = int'($urandom_range(b - 1, 0));
      else                        r = int'($urandom_range(15, 0));
      full_op(q, r, b);
    end

    // Reset during the second RUN cycle aborts the operation
    full_op(7, 9, 3);
    @(negedge clk);
    issue(13, 5, 11);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dividend", 32'(dividend), 32'd0);
    check("abort_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    quiet(8);
    full_op(4, 0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_divide_recombine
`default_nettype wire
